if_id_stall_resp: RTL and testbench
===================================

// Module: if_id_stall_resp
// PURPOSE
//  Consumer side of the load-use hazard handshake: takes Stall from the hazard checker
//  and Flush from EX branch resolution, and drives the front end of the 5-stage RV32I.
//  Freezes PC and the IF/ID register and forces an ID/EX bubble during a stall.
//  Squashes IF/ID on flush, and keeps stall statistics plus a stuck-stall watchdog.
// PARAMETERS
//  XLEN         32   PC/instruction width
//  STALL_CNT_W  16   width of saturating stall-cycle counter
//  MAX_STALL    4    consecutive HOLD cycles at which stall_err latches (>=1)
// PORTS
//  Clk        in   1                 rising-edge clock
//  Rst        in   1                 asynchronous reset, active-high
//  Stall      in   1                 load-use stall request from hazard checker (combinational)
//  Flush      in   1                 branch/jump taken in EX; squash younger instructions
//  if_pc      in   XLEN              PC of instruction in IF
//  if_instr   in   XLEN              fetched instruction
//  if_valid   in   1                 fetched instruction valid
//  pc_en      out  1                 PC register write enable
//  id_pc      out  XLEN              IF/ID PC
//  id_instr   out  XLEN              IF/ID instruction
//  id_valid   out  1                 IF/ID valid
//  ex_bubble  out  1                 force ID/EX control to NOP this cycle
//  stall_cnt  out  STALL_CNT_W       total stall cycles, saturating
//  stall_err  out  1                 sticky: stall held MAX_STALL consecutive cycles
// BEHAVIOUR
//  Definitions: NOP = 32'h0000_0013 (addi x0,x0,0); hold = Stall & ~Flush.
//  Reset (Rst=1, async): id_pc=0, id_instr=NOP, id_valid=0, stall_cnt=0, stall_err=0,
//   state=RUN, hold_len=0. Combinational outputs while Rst=1: pc_en=0, ex_bubble=1.
//  Combinational (zero latency, same cycle as inputs):
//   pc_en     = ~Rst & ~hold
//   ex_bubble = Rst | Flush | Stall | ~id_valid
//  IF/ID register, at posedge Clk, priority order:
//   1. Flush: id_valid<=0, id_instr<=NOP, id_pc<=if_pc. Flush wins over Stall.
//   2. Stall: id_pc, id_instr and id_valid hold their values.
//   3. Otherwise: id_pc<=if_pc, id_instr<=(if_valid ? if_instr : NOP), id_valid<=if_valid.
//  FSM (state register, 2 states):
//   RUN  -> HOLD when hold; otherwise stays in RUN.
//   HOLD -> HOLD while hold; -> RUN when ~Stall or Flush.
//   Stall release: the cycle Stall drops, pc_en=1 and IF/ID loads the held/next fetch.
//   No extra drain cycle. A stall re-raised on the next cycle re-enters HOLD directly.
//  hold_len counter (width $clog2(MAX_STALL+1)):
//   At posedge: hold ? sat_inc(hold_len) : 0.
//   When hold & hold_len==MAX_STALL-1, stall_err<=1 at that edge.
//   stall_err stays 1 until Rst; it has no effect on the pipeline.
//  stall_cnt: +1 at each posedge where hold=1; saturates at all-ones and never wraps.
//   Flush cycles are not counted.
//  Mid-operation reset: async clear from any state. pc_en drops immediately; a pending
//   hold is discarded.
//  Stall/Flush are sampled only as levels. There is no handshake ack and no edge detection.
// TESTING
//  1. Single load-use: Stall=1 one cycle with id_instr=0x00A50533 -> that cycle pc_en=0,
//     ex_bubble=1; id_instr unchanged after edge; next cycle pc_en=1; stall_cnt=1.
//  2. Stall 3 consecutive cycles, MAX_STALL=4 -> IF/ID frozen 3 edges, stall_cnt=3,
//     stall_err=0. Then Stall 4 cycles -> stall_err=1 after 4th edge, stays 1.
//  3. Stall=1 and Flush=1 same cycle, if_pc=0x100 -> pc_en=1, ex_bubble=1; after edge
//     id_valid=0, id_instr=0x00000013, id_pc=0x100; stall_cnt unchanged; state RUN.
//  4. if_valid=0 with no stall -> after edge id_valid=0, id_instr=NOP, ex_bubble=1.
//  5. Rst asserted mid-HOLD (asynchronous, between edges) -> pc_en=0 and id_valid=0
//     immediately; stall_cnt=0, stall_err=0; after release, first edge loads if_*.
//  6. STALL_CNT_W=4, Stall held 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/if_id_stall_resp.sv
// if_id_stall_resp: front-end response to load-use stalls and EX flushes, with stall statistics and watchdog
module if_id_stall_resp #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16,
  parameter int MAX_STALL   = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [XLEN-1:0]        if_pc,
  input  logic [XLEN-1:0]        if_instr,
  input  logic                   if_valid,
  output logic                   pc_en,
  output logic [XLEN-1:0]        id_pc,
  output logic [XLEN-1:0]        id_instr,
  output logic                   id_valid,
  output logic                   ex_bubble,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   stall_err
);
  localparam int HW = $clog2(MAX_STALL + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state;
  logic [HW-1:0] hold_len;
  logic hold;
  assign hold = Stall & ~Flush;
  assign pc_en = ~Rst & ~hold;
  assign ex_bubble = Rst | Flush | Stall | ~id_valid;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      id_pc     <= '0;
      id_instr  <= NOP;
      id_valid  <= 1'b0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
      state     <= RUN;
      hold_len  <= '0;
    end else begin
      if (Flush) begin
        id_valid <= 1'b0;
        id_instr <= NOP;
        id_pc    <= if_pc;
      end else if (!Stall) begin
        id_pc    <= if_pc;
        id_instr <= if_valid ? if_instr : NOP;
        id_valid <= if_valid;
      end
      state <= hold ? HOLD : RUN;
      // Entering HOLD from RUN always starts a fresh run of length one
      hold_len <= !hold ? '0 :
                  state == RUN ? HW'(1) :
                  hold_len == HW'(MAX_STALL) ? hold_len : hold_len + HW'(1);
      if (hold && hold_len == HW'(MAX_STALL - 1))
        stall_err <= 1'b1;
      if (hold && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_stall_resp.sv
// tb_if_id_stall_resp: directed vectors with a queue-based scoreboard and a negedge monitor
module tb_if_id_stall_resp;
  localparam logic [31:0] N = 32'h0000_0013;
  logic Clk = 0, Rst = 1, Stall = 0, Flush = 0, if_valid = 0;
  logic [31:0] if_pc = 0, if_instr = 0, id_pc, id_instr;
  logic pc_en, id_valid, ex_bubble, stall_err;
  logic [3:0] stall_cnt;
  int tests = 0, fails = 0, vid = 0;

  typedef struct {
    int id;
    logic pe, bub, iv, err;
    logic [31:0] ipc, iins;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];

  if_id_stall_resp #(.XLEN(32), .STALL_CNT_W(4), .MAX_STALL(4)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .pc_en(pc_en), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
    .ex_bubble(ex_bubble), .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input int id, input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, a, e);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "pc_en", 32'(pc_en), 32'(e.pe));
      chk(e.id, "ex_bubble", 32'(ex_bubble), 32'(e.bub));
      chk(e.id, "id_pc", id_pc, e.ipc);
      chk(e.id, "id_instr", id_instr, e.iins);
      chk(e.id, "id_valid", 32'(id_valid), 32'(e.iv));
      chk(e.id, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      chk(e.id, "stall_err", 32'(stall_err), 32'(e.err));
    end
  end

  // Drive one cycle's inputs and queue what the DUT must show before the next edge
  task automatic cyc(input logic r, s, f, input logic [31:0] pc, ins, input logic v,
                     input logic pe, bub, input logic [31:0] ipc, iins,
                     input logic iv, input logic [3:0] cnt, input logic err);
    Rst = r; Stall = s; Flush = f; if_pc = pc; if_instr = ins; if_valid = v;
    q.push_back('{vid, pe, bub, iv, err, ipc, iins, cnt});
    vid++;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    @(posedge Clk); #1;
    cyc(1,0,0,32'h0,  32'h0,       0, 0,1,32'h0,  N,           0,0,0);
    // single load-use
    cyc(0,0,0,32'h10, 32'h00A50533,1, 1,1,32'h0,  N,           0,0,0);
    cyc(0,1,0,32'h14, 32'h00B00593,1, 0,1,32'h10, 32'h00A50533,1,0,0);
    cyc(0,0,0,32'h14, 32'h00B00593,1, 1,0,32'h10, 32'h00A50533,1,1,0);
    // three-cycle stall: no watchdog
    cyc(0,1,0,32'h18, 32'h00C00613,1, 0,1,32'h14, 32'h00B00593,1,1,0);
    cyc(0,1,0,32'h18, 32'h00C00613,1, 0,1,32'h14, 32'h00B00593,1,2,0);
    cyc(0,1,0,32'h18, 32'h00C00613,1, 0,1,32'h14, 32'h00B00593,1,3,0);
    cyc(0,0,0,32'h18, 32'h00C00613,1, 1,0,32'h14, 32'h00B00593,1,4,0);
    // four-cycle stall: watchdog latches on the 4th edge
    cyc(0,1,0,32'h1C, 32'h00D00693,1, 0,1,32'h18, 32'h00C00613,1,4,0);
    cyc(0,1,0,32'h1C, 32'h00D00693,1, 0,1,32'h18, 32'h00C00613,1,5,0);
    cyc(0,1,0,32'h1C, 32'h00D00693,1, 0,1,32'h18, 32'h00C00613,1,6,0);
    cyc(0,1,0,32'h1C, 32'h00D00693,1, 0,1,32'h18, 32'h00C00613,1,7,0);
    cyc(0,0,0,32'h1C, 32'h00D00693,1, 1,0,32'h18, 32'h00C00613,1,8,1);
    cyc(0,0,0,32'h20, 32'h00E00713,1, 1,0,32'h1C, 32'h00D00693,1,8,1);
    // stall and flush together: flush wins, not counted
    cyc(0,1,1,32'h100,32'h00F00793,1, 1,1,32'h20, 32'h00E00713,1,8,1);
    cyc(0,0,0,32'h104,32'h01000813,1, 1,1,32'h100,N,           0,8,1);
    // invalid fetch becomes a NOP bubble
    cyc(0,0,0,32'h108,32'h01100893,0, 1,0,32'h104,32'h01000813,1,8,1);
    cyc(0,0,0,32'h10C,32'h01200913,1, 1,1,32'h108,N,           0,8,1);
    // async reset in the middle of a hold
    cyc(0,1,0,32'h110,32'h01300993,1, 0,1,32'h10C,32'h01200913,1,8,1);
    cyc(1,1,0,32'h110,32'h01300993,1, 0,1,32'h0,  N,           0,0,0);
    cyc(0,0,0,32'h200,32'h01400A13,1, 1,1,32'h0,  N,           0,0,0);
    cyc(0,0,0,32'h204,32'h01500A93,1, 1,0,32'h200,32'h01400A13,1,0,0);
    // 20-cycle stall: counter saturates at 15
    for (int i = 0; i < 20; i++)
      cyc(0,1,0,32'h208,32'h01600B13,1, 0,1,32'h204,32'h01500A93,1,
          (i > 15) ? 4'd15 : 4'(i), i >= 4);
    cyc(0,0,0,32'h208,32'h01600B13,1, 1,0,32'h204,32'h01500A93,1,15,1);
    Stall = 0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge Clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
